// File: rtl/mem_responder.sv
// Single-request memory responder for the MAR/MDR bus: latches a read or write,
// services a word RAM with a fixed read latency and pulses mem_ready on completion.
module mem_responder #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [31:0]       MAR_q,
  input  logic [DATA_W-1:0] MDR_q,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_ready,
  output logic              busy,
  output logic              addr_err,
  output logic [1:0]        state_dbg
);

  // IDLE is encoded as 0 so the debug view reads 0 out of reset.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_DONE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  state_t            state;
  logic [1:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              mem_we;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  assign state_dbg = state;

  // Reset forces state to IDLE asynchronously, so a pending write is dropped.
  assign mem_we = (state == WR_DONE) && !err_q;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      Mdatain   <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      addr_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (Read || Write) begin
            idx_q   <= MAR_q[ADDR_W-1:0];
            wdata_q <= MDR_q;
            err_q   <= |MAR_q[31:ADDR_W];
            cnt     <= LAT_M1;
            busy    <= 1'b1;
            // Read has priority; a simultaneous Write is simply dropped.
            state   <= Read ? RD_WAIT : WR_DONE;
          end
        end
        RD_WAIT: begin
          if (cnt == 2'd0) begin
            Mdatain   <= err_q ? '0 : mem[idx_q];
            mem_ready <= 1'b1;
            addr_err  <= err_q;
            state     <= DONE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        WR_DONE: begin
          mem_ready <= 1'b1;
          addr_err  <= err_q;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances with RD_LAT 1..4 sharing clock and reset,
// a directed vector table, hand-written corner sequences and a randomized model check.
module tb_mem_responder;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        clear;
  logic        rd   [N];
  logic        wr   [N];
  logic [31:0] mar  [N];
  logic [31:0] mdr  [N];
  logic [31:0] mdat [N];
  logic        rdy  [N];
  logic        bsy  [N];
  logic        aerr [N];
  logic [1:0]  st   [N];

  int n_cmp = 0;
  int n_bad = 0;

  // clock/reset block
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(.ADDR_W(9), .DATA_W(32), .RD_LAT(g + 1)) u_dut (
      .clock    (clk),
      .clear    (clear),
      .Read     (rd[g]),
      .Write    (wr[g]),
      .MAR_q    (mar[g]),
      .MDR_q    (mdr[g]),
      .Mdatain  (mdat[g]),
      .mem_ready(rdy[g]),
      .busy     (bsy[g]),
      .addr_err (aerr[g]),
      .state_dbg(st[g])
    );
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model and scoreboard
  logic [31:0] mem_m   [N][512];
  logic [31:0] last_rd [N];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected result of one transfer, from the behavioural rules alone.
  task automatic model_op(input int i, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] eq, output bit ee,
                          output int el);
    ee = (a >= 32'd512);
    if (r) begin
      eq = ee ? 32'h0 : mem_m[i][a % 512];
      last_rd[i] = eq;
      el = i + 1;
    end else begin
      if (w && !ee) mem_m[i][a % 512] = d;
      eq = last_rd[i];
      el = 1;
    end
  endtask

  // driver: one request held until mem_ready, then released
  task automatic xfer(input int i, input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] q, output bit e,
                      output int lat, output int bcy, output logic [1:0] post);
    @(negedge clk);
    rd[i] = r; wr[i] = w; mar[i] = a; mdr[i] = d;
    lat = -1; bcy = 0;
    @(posedge clk);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bsy[i]) bcy++;
      if (rdy[i]) begin
        lat = t;
        break;
      end
    end
    q = mdat[i];
    e = aerr[i];
    rd[i] = 1'b0; wr[i] = 1'b0;
    @(negedge clk);
    post = {rdy[i], bsy[i]};
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] q;
    bit          e;
    int          lat;
  } vec_t;

  vec_t        tbl [14];
  logic [31:0] q;
  bit          e;
  int          lat, bcy, cnt_rdy, got_lat;
  logic [1:0]  post;
  logic [31:0] alist [7];

  initial begin
    clear = 1'b1;
    for (int i = 0; i < N; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; mar[i] = '0; mdr[i] = '0;
    end

    // power-on reset, asserted before any clock edge
    #3 clear = 1'b0;
    #1;
    for (int i = 0; i < N; i++)
      check($sformatf("por_outputs_%0d", i), {mdat[i], rdy[i], bsy[i], aerr[i], st[i]}, 64'h0);
    repeat (3) @(negedge clk);
    clear = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++)
      check($sformatf("post_release_%0d", i), {mdat[i], rdy[i], bsy[i], aerr[i]}, 64'h0);

    // directed table on the RD_LAT=2 instance
    tbl[0]  = '{1'b0, 1'b1, 32'h090, 32'h00800085, 32'h00000000, 1'b0, 1};
    tbl[1]  = '{1'b1, 1'b0, 32'h090, 32'h77777777, 32'h00800085, 1'b0, 2};
    tbl[2]  = '{1'b0, 1'b1, 32'h010, 32'h11111111, 32'h00800085, 1'b0, 1};
    tbl[3]  = '{1'b1, 1'b1, 32'h010, 32'hDEADBEEF, 32'h11111111, 1'b0, 2};
    tbl[4]  = '{1'b1, 1'b0, 32'h010, 32'h77777777, 32'h11111111, 1'b0, 2};
    tbl[5]  = '{1'b0, 1'b1, 32'h1FF, 32'hA5A5A5A5, 32'h11111111, 1'b0, 1};
    tbl[6]  = '{1'b1, 1'b0, 32'h1FF, 32'h77777777, 32'hA5A5A5A5, 1'b0, 2};
    tbl[7]  = '{1'b0, 1'b1, 32'h000, 32'h0BADF00D, 32'hA5A5A5A5, 1'b0, 1};
    tbl[8]  = '{1'b0, 1'b1, 32'h200, 32'hFFFFFFFF, 32'hA5A5A5A5, 1'b1, 1};
    tbl[9]  = '{1'b1, 1'b0, 32'h200, 32'h77777777, 32'h00000000, 1'b1, 2};
    tbl[10] = '{1'b1, 1'b0, 32'h000, 32'h77777777, 32'h0BADF00D, 1'b0, 2};
    tbl[11] = '{1'b0, 1'b1, 32'h090, 32'h5555AAAA, 32'h0BADF00D, 1'b0, 1};
    tbl[12] = '{1'b1, 1'b0, 32'h090, 32'h77777777, 32'h5555AAAA, 1'b0, 2};
    tbl[13] = '{1'b0, 1'b1, 32'h090, 32'h01234567, 32'h5555AAAA, 1'b0, 1};
    for (int v = 0; v < 14; v++) begin
      xfer(1, tbl[v].r, tbl[v].w, tbl[v].a, tbl[v].d, q, e, lat, bcy, post);
      check($sformatf("tbl%0d_mdatain", v), q, tbl[v].q);
      check($sformatf("tbl%0d_addr_err", v), 64'(e), 64'(tbl[v].e));
      check($sformatf("tbl%0d_latency", v), 64'(lat), 64'(tbl[v].lat));
      check($sformatf("tbl%0d_busy_cycles", v), 64'(bcy), 64'(tbl[v].lat + 1));
      check($sformatf("tbl%0d_idle_after", v), 64'(post), 64'h0);
    end

    // latency sweep across all instances
    for (int i = 0; i < N; i++) begin
      xfer(i, 1'b0, 1'b1, 32'h090, 32'h00800085, q, e, lat, bcy, post);
      xfer(i, 1'b1, 1'b0, 32'h090, 32'h0, q, e, lat, bcy, post);
      check($sformatf("sweep%0d_data", i), q, 32'h00800085);
      check($sformatf("sweep%0d_latency", i), 64'(lat), 64'(i + 1));
      check($sformatf("sweep%0d_busy_cycles", i), 64'(bcy), 64'(i + 2));
      check($sformatf("sweep%0d_addr_err", i), 64'(e), 64'h0);
    end

    // Write pulsed during RD_WAIT on the RD_LAT=4 instance is ignored
    @(negedge clk);
    rd[3] = 1'b1; mar[3] = 32'h090; mdr[3] = 32'h0;
    @(posedge clk);
    got_lat = -1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (rdy[3]) begin
        got_lat = t;
        break;
      end
      if (t == 0) begin wr[3] = 1'b1; mdr[3] = 32'hFFFF0000; end
      if (t == 1) wr[3] = 1'b0;
    end
    check("rdwait_write_latency", 64'(got_lat), 64'd4);
    check("rdwait_write_data", mdat[3], 32'h00800085);
    rd[3] = 1'b0;
    @(negedge clk);
    check("rdwait_write_idle", 64'(bsy[3]), 64'h0);
    xfer(3, 1'b1, 1'b0, 32'h090, 32'h0, q, e, lat, bcy, post);
    check("rdwait_write_readback", q, 32'h00800085);

    // mid-cycle reset with a read in flight on instance 3
    @(negedge clk);
    rd[3] = 1'b1; mar[3] = 32'h090;
    @(posedge clk);
    #2 clear = 1'b0;
    rd[3] = 1'b0;
    #1;
    for (int i = 0; i < N; i++)
      check($sformatf("midcycle_reset_%0d", i), {mdat[i], rdy[i], bsy[i], aerr[i], st[i]}, 64'h0);
    @(negedge clk);
    clear = 1'b1;
    cnt_rdy = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy[3]) cnt_rdy++;
    end
    check("midcycle_no_ready", 64'(cnt_rdy), 64'h0);
    check("midcycle_mdatain_kept0", mdat[3], 32'h0);

    // abort a write on instance 1 before its completion edge
    xfer(1, 1'b0, 1'b1, 32'h020, 32'h0, q, e, lat, bcy, post);
    @(negedge clk);
    wr[1] = 1'b1; mar[1] = 32'h020; mdr[1] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", 64'(bsy[1]), 64'h1);
    clear = 1'b0;
    wr[1] = 1'b0;
    #1 check("abort_outputs", {rdy[1], bsy[1], aerr[1]}, 64'h0);
    cnt_rdy = 0;
    @(negedge clk);
    clear = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rdy[1]) cnt_rdy++;
    end
    check("abort_no_ready", 64'(cnt_rdy), 64'h0);
    xfer(1, 1'b1, 1'b0, 32'h020, 32'h0, q, e, lat, bcy, post);
    check("abort_readback", q, 32'h0);

    // randomized transfers against the model
    alist = '{32'h000, 32'h001, 32'h0AA, 32'h1FE, 32'h1FF, 32'h200, 32'h80000005};
    for (int i = 0; i < N; i++) begin
      logic [31:0] eq;
      bit          ee;
      int          el;
      last_rd[i] = 32'h0;
      for (int k = 0; k < 5; k++) begin
        logic [31:0] dv;
        dv = $urandom;
        model_op(i, 1'b0, 1'b1, alist[k], dv, eq, ee, el);
        xfer(i, 1'b0, 1'b1, alist[k], dv, q, e, lat, bcy, post);
      end
      for (int n = 0; n < 30; n++) begin
        int          kind;
        bit          r, w;
        logic [31:0] a, dv;
        kind = $urandom_range(0, 3);
        r = (kind != 1);
        w = (kind == 1) || (kind == 2);
        a = alist[$urandom_range(0, 6)];
        dv = $urandom;
        model_op(i, r, w, a, dv, eq, ee, el);
        exp_q.push_back(eq);
        xfer(i, r, w, a, dv, q, e, lat, bcy, post);
        check($sformatf("rnd%0d_%0d_mdatain", i, n), q, exp_q.pop_front());
        check($sformatf("rnd%0d_%0d_addr_err", i, n), 64'(e), 64'(ee));
        check($sformatf("rnd%0d_%0d_latency", i, n), 64'(lat), 64'(el));
        check($sformatf("rnd%0d_%0d_idle_after", i, n), 64'(post), 64'h0);
      end
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
